// File: rtl/step_dir_if.sv
// Move-command / step-dir bundle shared by the command logic and step_dir_gen.
interface step_dir_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] target;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] pos;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, target,
        input  step, dir, pos, busy, done
    );

    modport slave (
        input  start, abort, target,
        output step, dir, pos, busy, done
    );
endinterface

// File: rtl/step_dir_gen.sv
// Step/direction transmitter: walks a mirrored position to a latched target,
// one step pulse every DIV clocks, all outputs registered.
//
// state | meaning
// IDLE  | waiting for start; pos holds last position
// SETUP | target latched, dir driven one cycle ahead of first step
// STEP  | step pulse high; pos moves on the edge ending this cycle
// WAIT  | step low for DIV-1 cycles before the next STEP
// DONE  | one-cycle done pulse, then back to IDLE
module step_dir_gen #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    step_dir_if.slave  bus
);
    localparam int CW = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("step_dir_gen: DIV must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pos;
    logic [WIDTH-1:0] w_pos_nxt;
    logic [WIDTH-1:0] w_pos_step;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_target_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_step;
    logic             r_busy;
    logic             r_done;

    assign w_pos_step = r_dir ? (r_pos + WIDTH'(1)) : (r_pos - WIDTH'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_target_nxt = r_target;
        w_dir_nxt    = r_dir;
        w_cnt_nxt    = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.target != r_pos) begin
                        w_target_nxt = bus.target;
                        w_dir_nxt    = (bus.target > r_pos);
                        w_state_nxt  = S_SETUP;
                    end else begin
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt = bus.abort ? S_DONE : S_STEP;
            end
            S_STEP: begin
                // The pulse always completes; abort only decides where we go next.
                w_pos_nxt = w_pos_step;
                if ((w_pos_step == r_target) || bus.abort) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CW'(DIV - 2);
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pos    <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir    <= w_dir_nxt;
        end
    end

    // Status outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_step <= (w_state_nxt == S_STEP);
            r_busy <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_STEP) ||
                      (w_state_nxt == S_WAIT);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.step = r_step;
    assign bus.dir  = r_dir;
    assign bus.pos  = r_pos;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: doc/step_dir_gen.md
Name: step_dir_gen

Overview:
- Step/direction transmitter. Drives the count-enable (step) and direction (dir) inputs of the team's up/down position counter.
- Keeps an internal mirror of the counter position and moves it to a requested target, one step per DIV clocks.
- Sits between the control logic that issues move commands and the counter/actuator that receives the step/dir pair.

Parameters:
- WIDTH, 4, width of the target and position values (unsigned).
- DIV, 4, clocks per step period: step is high 1 cycle, then low DIV-1 cycles. Must be >= 2; a value below 2 is a configuration error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  move request; sampled only in IDLE.
- abort  in  1  stop request; sampled while busy.
- target  in  WIDTH  destination position; latched when start is accepted.
- step  out  1  one-cycle step pulse to the counter.
- dir  out  1  direction: 1 = up (+1), 0 = down (-1).
- pos  out  WIDTH  mirrored position.
- busy  out  1  high in SETUP, STEP and WAIT.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE, pos=0, step=0, dir=0, busy=0, done=0, wait counter=0, latched target=0.
- All outputs are registered.
- FSM states: IDLE, SETUP, STEP, WAIT, DONE.
- IDLE:
  - start=1 with target != pos: latch target; next state SETUP; dir <= (target > pos), unsigned compare.
  - start=1 with target == pos: next state DONE; no step issued.
  - start=0: stay in IDLE.
- SETUP: lasts exactly 1 cycle, so dir is stable one cycle before the first step. Next state STEP, or DONE if abort=1.
- STEP:
  - step=1 for exactly 1 cycle.
  - On the edge ending the STEP cycle: pos <= pos+1 if dir=1, else pos-1 (mod 2^WIDTH).
  - This is the same edge on which the counter samples step, so pos and the counter update together.
  - Next state DONE if the new pos == latched target or abort=1; otherwise WAIT.
- WAIT:
  - step=0 for DIV-1 cycles, counted with a ceil(log2(DIV))-bit counter; then STEP.
  - abort=1 in any WAIT cycle: next state DONE immediately.
- DONE: done=1 for 1 cycle, busy=0; next state IDLE.
- start is ignored in every state except IDLE, including DONE. target changes after latching have no effect.
- dir changes only on entry to SETUP and holds its value until the next accepted start.
- No wrap path: direction comes from a plain unsigned compare, so 0 -> 15 takes 15 up-steps, never 1 down-step.
- Arithmetic wrap cannot occur in normal operation, because movement stops at the target.
- abort in IDLE or DONE is ignored. Abort never truncates a step pulse in progress; the pulse completes and pos updates first.
- Latency from an accepted start (edge E0):
  - busy from cycle 1.
  - first step in cycle 2.
  - step k in cycle 2 + (k-1)*DIV.
  - done in the cycle after the last step.
- Reset mid-move: step deasserts immediately and pos returns to 0. The external counter must share the same reset.

Test Plan:
- Reset then idle: rst pulse, no start -> step=0, dir=0, pos=0, busy=0, done=0 held for 20 cycles.
- Up move, DIV=4, pos=0, start with target=3 in cycle 0 -> dir=1 from cycle 1; step high in cycles 2, 6 and 10 only; pos 1/2/3 visible in cycles 3/7/11; busy high in cycles 1-10; done high in cycle 11 only.
- Down move from pos=3, start with target=1 -> dir=0 one cycle before the first step; exactly 2 step pulses DIV apart; pos 3->2->1; one done pulse; a paired up/down counter reads 1.
- Zero move: pos=5, start with target=5 -> done on the next cycle; no step pulse; busy never asserts; dir unchanged.
- Abort: pos=0, target=15, abort in the 2nd WAIT cycle after step 2 -> no further step; pos=2; done next cycle; start pulsed during busy is ignored (no second move).
- Async reset mid-move: rst asserted between clock edges during a STEP cycle -> step, busy and pos go to 0 without waiting for a clock edge; after release, a new start with target=2 completes normally with 2 steps.
